serial_add_ctrl: RTL



---
 rtl/serial_add_ctrl_pkg.sv | 12 +
 rtl/adder_slice3.sv | 23 ++
 rtl/serial_add_ctrl.sv | 109 ++++++++++
 3 files changed

// File: rtl/serial_add_ctrl_pkg.sv
// rtl/serial_add_ctrl_pkg.sv - shared chunk width and FSM state encoding for the serial adder
package serial_add_ctrl_pkg;

    localparam int CHUNK_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/adder_slice3.sv
// rtl/adder_slice3.sv - combinational 3-bit ripple-carry adder slice
module adder_slice3
    import serial_add_ctrl_pkg::*;
(
    input  logic [CHUNK_W-1:0] a,
    input  logic [CHUNK_W-1:0] b,
    input  logic               cin,
    output logic [CHUNK_W-1:0] sum,
    output logic               cout
);

    logic [CHUNK_W:0] w_c;

    assign w_c[0] = cin;

    for (genvar i = 0; i < CHUNK_W; i++) begin : g_bit
        assign sum[i]   = a[i] ^ b[i] ^ w_c[i];
        assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
    end

    assign cout = w_c[CHUNK_W];

endmodule

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - chunk-serial wide adder sequenced over one shared 3-bit slice
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter  int NUM_CHUNKS = 4,
    localparam int W          = CHUNK_W * NUM_CHUNKS
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a_in,
    input  logic [W-1:0] b_in,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum_out,
    output logic         cout_out
);

    localparam int                 IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(NUM_CHUNKS - 1);
    localparam logic [W-1:0]       CHUNK_MASK = W'((1 << CHUNK_W) - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [W-1:0]       r_a;
    logic [W-1:0]       r_b;
    logic [W-1:0]       r_acc;
    logic [W-1:0]       r_sum;
    logic               r_carry;
    logic               r_cout;
    logic [IDX_W-1:0]   r_idx;

    logic [31:0]        w_shamt;
    logic [CHUNK_W-1:0] w_a_chunk;
    logic [CHUNK_W-1:0] w_b_chunk;
    logic [CHUNK_W-1:0] w_slice_sum;
    logic               w_slice_cout;
    logic [W-1:0]       w_acc_nxt;
    logic               w_last;

    // Shifts instead of indexed part-selects keep the chunk mux legal for any NUM_CHUNKS.
    assign w_shamt   = 32'(r_idx) * 32'(CHUNK_W);
    assign w_a_chunk = CHUNK_W'(r_a >> w_shamt);
    assign w_b_chunk = CHUNK_W'(r_b >> w_shamt);
    assign w_last    = (r_idx == LAST_IDX);
    assign w_acc_nxt = (r_acc & ~(CHUNK_MASK << w_shamt)) | (W'(w_slice_sum) << w_shamt);

    adder_slice3 u_slice (
        .a    (w_a_chunk),
        .b    (w_b_chunk),
        .cin  (r_carry),
        .sum  (w_slice_sum),
        .cout (w_slice_cout)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start)  w_state_nxt = ST_ADD;
            ST_ADD:  if (w_last) w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a     <= a_in;
                        r_b     <= b_in;
                        r_carry <= cin;
                        r_idx   <= '0;
                    end
                end
                ST_ADD: begin
                    r_acc   <= w_acc_nxt;
                    r_carry <= w_slice_cout;
                    // Publish the final chunk together with the rest so results appear with done.
                    if (w_last) begin
                        r_sum  <= w_acc_nxt;
                        r_cout <= w_slice_cout;
                    end else begin
                        r_idx  <= r_idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy     = (r_state == ST_ADD);
    assign done     = (r_state == ST_DONE);
    assign sum_out  = r_sum;
    assign cout_out = r_cout;

endmodule
